// File: rtl/serial_subtractor.sv
// Bit-serial subtractor D = A - B - Bin, LSB first, one bit per clock; result after WIDTH+1 cycles.
// No backpressure: start is taken only in IDLE and ignored while an operation is in flight.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] r_sr_q, r_sr_d;
   logic             br_q, br_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bout_q, bout_d;

   logic             d_bit;
   logic             br_nxt;
   logic [WIDTH-1:0] r_nxt;

   always_comb begin
      state_d = state_q;
      a_sr_d  = a_sr_q;
      b_sr_d  = b_sr_q;
      r_sr_d  = r_sr_q;
      br_d    = br_q;
      cnt_d   = cnt_q;
      diff_d  = diff_q;
      bout_d  = bout_q;

      // the single shared full-subtractor cell
      d_bit  = a_sr_q[0] ^ b_sr_q[0] ^ br_q;
      br_nxt = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & br_q);
      r_nxt  = {d_bit, r_sr_q[WIDTH-1:1]};

      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_sr_d  = a;
               b_sr_d  = b;
               br_d    = bin;
               r_sr_d  = '0;
               cnt_d   = '0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            a_sr_d = a_sr_q >> 1;
            b_sr_d = b_sr_q >> 1;
            br_d   = br_nxt;
            r_sr_d = r_nxt;
            cnt_d  = cnt_q + CW'(1);
            // publish the result including the bit computed on this very edge
            if (cnt_q == LAST) begin
               diff_d  = r_nxt;
               bout_d  = br_nxt;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         r_sr_q  <= '0;
         br_q    <= 1'b0;
         cnt_q   <= '0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sr_q  <= a_sr_d;
         b_sr_q  <= b_sr_d;
         r_sr_q  <= r_sr_d;
         br_q    <= br_d;
         cnt_q   <= cnt_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
      end
   end

   assign busy = (state_q == S_SHIFT);
   assign done = (state_q == S_DONE);
   assign diff = diff_q;
   assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed table, multi-cycle corner sequences, random and exhaustive WIDTH=4.
module tb_serial_subtractor;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       start, bin, busy, done, bout;
   logic [7:0] a, b, diff;

   logic       start4, bin4, busy4, done4, bout4;
   logic [3:0] a4, b4, diff4;

   int checks   = 0;
   int failures = 0;

   serial_subtractor #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
      .busy(busy), .done(done), .diff(diff), .bout(bout)
   );

   serial_subtractor #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
      .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
   );

   typedef struct {
      int a;
      int b;
      int bin;
      int exp_diff;
      int exp_bout;
   } vec_t;

   vec_t vecs [4];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // reference: {bout, diff} is the (W+1)-bit wrap-around of a - b - bin
   function automatic int ref_sub(input int av, input int bv, input int binv, input int w);
      int r;
      r = av - bv - binv;
      return r & ((1 << (w + 1)) - 1);
   endfunction

   task automatic run_op8(input int av, input int bv, input int binv,
                          output int rd, output int rb, output int lat);
      a = 8'(av); b = 8'(bv); bin = 1'(binv); start = 1'b1;
      tick();
      start = 1'b0;
      a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
      lat = 0;
      while (!done && lat < 20) begin
         tick();
         lat++;
      end
      if (!done) chk("done_timeout8", 0, 1);
      rd = int'(diff); rb = int'(bout);
      tick();
   endtask

   task automatic run_op4(input int av, input int bv, input int binv,
                          output int rd, output int rb);
      int n;
      a4 = 4'(av); b4 = 4'(bv); bin4 = 1'(binv); start4 = 1'b1;
      tick();
      start4 = 1'b0;
      n = 0;
      while (!done4 && n < 12) begin
         tick();
         n++;
      end
      if (!done4) chk("done_timeout4", 0, 1);
      rd = int'(diff4); rb = int'(bout4);
      tick();
   endtask

   initial begin
      int rd, rb, lat, exp, ndone, last_done, cyc;

      vecs[0] = '{100, 37,   0, 8'h3F, 0};
      vecs[1] = '{5,   10,   0, 8'hFB, 1};
      vecs[2] = '{0,   0,    1, 8'hFF, 1};
      vecs[3] = '{128, 127,  1, 8'h00, 0};

      rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
      start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
      tick(); tick();
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_diff", int'(diff), 0);
      chk("rst_bout", int'(bout), 0);
      rst = 1'b0;
      tick();

      // T1 timing: busy in cycles 1..8, done only in cycle 9
      a = 8'd100; b = 8'd37; bin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0; a = 8'hAA; b = 8'h55; bin = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         chk($sformatf("t1_busy_c%0d", c), int'(busy), 1);
         chk($sformatf("t1_done_c%0d", c), int'(done), 0);
         if (c > 1) chk($sformatf("t1_diff_stable_c%0d", c), int'(diff), 0);
         tick();
      end
      chk("t1_done_c9", int'(done), 1);
      chk("t1_busy_c9", int'(busy), 0);
      chk("t1_diff", int'(diff), 63);
      chk("t1_bout", int'(bout), 0);
      tick();
      chk("t1_done_c10", int'(done), 0);
      chk("t1_diff_hold", int'(diff), 63);

      for (int i = 0; i < 4; i++) begin
         run_op8(vecs[i].a, vecs[i].b, vecs[i].bin, rd, rb, lat);
         chk($sformatf("vec%0d_diff", i), rd, vecs[i].exp_diff);
         chk($sformatf("vec%0d_bout", i), rb, vecs[i].exp_bout);
         chk($sformatf("vec%0d_latency", i), lat, 8);
      end

      // T3: start during SHIFT is ignored
      a = 8'd200; b = 8'd1; bin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      ndone = 0;
      for (int c = 1; c <= 25; c++) begin
         if (c == 4) begin
            a = 8'd9; b = 8'd9; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (done) begin
            ndone++;
            chk("t3_diff", int'(diff), 199);
            chk("t3_bout", int'(bout), 0);
         end
         tick();
      end
      chk("t3_done_count", ndone, 1);

      // T4: start held high gives done pulses WIDTH+2 apart
      a = 8'd50; b = 8'd20; bin = 1'b0; start = 1'b1;
      ndone = 0; last_done = -1;
      for (int c = 0; c < 42; c++) begin
         if (done) begin
            if (last_done >= 0) chk("t4_spacing", c - last_done, 10);
            chk("t4_diff", int'(diff), 30);
            chk("t4_busy_in_done", int'(busy), 0);
            last_done = c;
            ndone++;
         end
         tick();
      end
      chk("t4_done_count", ndone, 4);
      start = 1'b0;
      cyc = 0;
      while ((busy || done) && cyc < 20) begin
         tick();
         cyc++;
      end
      chk("t4_drain", int'(busy | done), 0);
      tick();

      // T5: reset mid-SHIFT aborts without a done pulse
      a = 8'd77; b = 8'd11; bin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_busy", int'(busy), 0);
      chk("t5_done", int'(done), 0);
      chk("t5_diff", int'(diff), 0);
      chk("t5_bout", int'(bout), 0);
      ndone = 0;
      for (int c = 0; c < 15; c++) begin
         if (done) ndone++;
         tick();
      end
      chk("t5_no_done", ndone, 0);
      run_op8(7, 3, 0, rd, rb, lat);
      chk("t5_next_diff", rd, 4);
      chk("t5_next_bout", rb, 0);

      for (int i = 0; i < 150; i++) begin
         int ra, rbv, rbi;
         ra = int'($urandom_range(255)); rbv = int'($urandom_range(255)); rbi = int'($urandom_range(1));
         exp = ref_sub(ra, rbv, rbi, 8);
         run_op8(ra, rbv, rbi, rd, rb, lat);
         chk($sformatf("rnd %0d-%0d-%0d", ra, rbv, rbi), (rb << 8) | rd, exp);
      end

      // T6: exhaustive WIDTH=4
      for (int av = 0; av < 16; av++)
         for (int bv = 0; bv < 16; bv++)
            for (int bi = 0; bi < 2; bi++) begin
               exp = ref_sub(av, bv, bi, 4);
               run_op4(av, bv, bi, rd, rb);
               chk($sformatf("w4 %0d-%0d-%0d", av, bv, bi), (rb << 4) | rd, exp);
            end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
